// File: rtl/cordic_arbiter.sv
// cordic_arbiter: two-requester round-robin front end for a shared
// combinational CORDIC unit, with operand capture, settle timer and
// a held response until the consumer accepts it.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqK_valid/ready          requester K handshake (K=0,1)
//   reqK_mode                 1=trig (sin/cos), 0=rotate (x,y)
//   reqK_angle, reqK_x/y      Q4.28 operands
//   cu_trig_rot, cu_angle,
//   cu_xi, cu_yi              operands to the CORDIC unit (registered)
//   cu_sin/cos/xr/yr          CORDIC unit results
//   rsp_valid/ready, rsp_id,
//   rsp_a, rsp_b              response (trig: sin,cos; rotate: xr,yr)
//   busy                      high whenever not IDLE
//
// Optional macro CORDIC_ARB_QUADRANT_EN folds angles beyond +-pi/2
// into range by +-pi and negates both results.
module cordic_arbiter #(
    parameter int N      = 32,
    parameter int SETTLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_mode,
    input  logic [N-1:0] req0_angle,
    input  logic [N-1:0] req0_x,
    input  logic [N-1:0] req0_y,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_mode,
    input  logic [N-1:0] req1_angle,
    input  logic [N-1:0] req1_x,
    input  logic [N-1:0] req1_y,
    output logic         cu_trig_rot,
    output logic [N-1:0] cu_angle,
    output logic [N-1:0] cu_xi,
    output logic [N-1:0] cu_yi,
    input  logic [N-1:0] cu_sin,
    input  logic [N-1:0] cu_cos,
    input  logic [N-1:0] cu_xr,
    input  logic [N-1:0] cu_yr,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_a,
    output logic [N-1:0] rsp_b,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]   r_state;
    logic [3:0]   r_cnt;
    logic         r_last;
    logic         r_mode;
    logic [N-1:0] r_angle;
    logic [N-1:0] r_x;
    logic [N-1:0] r_y;
    logic         r_id;
    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic [N-1:0] r_rsp_a;
    logic [N-1:0] r_rsp_b;

    logic         w_idle;
    logic         w_gnt1;
    logic         w_acc;
    logic [N-1:0] w_sel_a;
    logic [N-1:0] w_sel_b;
    logic [N-1:0] w_res_a;
    logic [N-1:0] w_res_b;
    logic [N-1:0] w_cu_angle;

    assign w_idle = (r_state == S_IDLE);

    // req1 wins alone, or on a tie when req0 was granted last.
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);

    assign req0_ready = ~rst & w_idle & req0_valid & ~w_gnt1;
    assign req1_ready = ~rst & w_idle & w_gnt1;
    assign w_acc      = req0_ready | req1_ready;

    assign w_sel_a = r_mode ? cu_sin : cu_xr;
    assign w_sel_b = r_mode ? cu_cos : cu_yr;

`ifdef CORDIC_ARB_QUADRANT_EN
    localparam logic [63:0]  PI_W  = {32'h3243F6A9, 32'h0};
    localparam logic [63:0]  PI2_W = {32'h1921FB54, 32'h0};
    localparam logic [N-1:0] PI    = PI_W[63 -: N];
    localparam logic [N-1:0] PI_2  = PI2_W[63 -: N];
    localparam logic [N-1:0] NPI_2 = -PI_2;

    logic w_hi;
    logic w_lo;

    assign w_hi = $signed(r_angle) > $signed(PI_2);
    assign w_lo = $signed(r_angle) < $signed(NPI_2);

    assign w_cu_angle = w_hi ? r_angle - PI :
                        w_lo ? r_angle + PI : r_angle;
    assign w_res_a    = (w_hi | w_lo) ? -w_sel_a : w_sel_a;
    assign w_res_b    = (w_hi | w_lo) ? -w_sel_b : w_sel_b;
`else
    assign w_cu_angle = r_angle;
    assign w_res_a    = w_sel_a;
    assign w_res_b    = w_sel_b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_last      <= 1'b1;
            r_mode      <= 1'b0;
            r_angle     <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_a     <= '0;
            r_rsp_b     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_mode  <= w_gnt1 ? req1_mode  : req0_mode;
                        r_angle <= w_gnt1 ? req1_angle : req0_angle;
                        r_x     <= w_gnt1 ? req1_x     : req0_x;
                        r_y     <= w_gnt1 ? req1_y     : req0_y;
                        r_id    <= w_gnt1;
                        r_last  <= w_gnt1;
                        r_cnt   <= 4'd0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Counter reaches SETTLE-1 on the SETTLE-th edge.
                    if (r_cnt == 4'(SETTLE - 1)) begin
                        r_rsp_a     <= w_res_a;
                        r_rsp_b     <= w_res_b;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cu_trig_rot = r_mode;
    assign cu_angle    = w_cu_angle;
    assign cu_xi       = r_x;
    assign cu_yi       = r_y;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_a       = r_rsp_a;
    assign rsp_b       = r_rsp_b;
    assign busy        = ~w_idle;

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed checks of arbitration, timing, hold,
// reset abort and angle folding against a table-driven CORDIC stub.
module tb_cordic_arbiter;

    localparam int N = 32;

    localparam logic [N-1:0] PI3   = 32'h10C15238;
    localparam logic [N-1:0] PI6   = 32'h0860A91C;
    localparam logic [N-1:0] SIN60 = 32'h0DDB3D74;
    localparam logic [N-1:0] HALF  = 32'h08000000;
    localparam logic [N-1:0] ONE   = 32'h10000000;
    localparam logic [N-1:0] PIA   = 32'h3243F6A8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_mode;
    logic [N-1:0] req0_angle, req0_x, req0_y;
    logic         req1_valid, req1_ready, req1_mode;
    logic [N-1:0] req1_angle, req1_x, req1_y;
    logic         cu_trig_rot;
    logic [N-1:0] cu_angle, cu_xi, cu_yi;
    logic [N-1:0] cu_sin, cu_cos, cu_xr, cu_yr;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_a, rsp_b;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cordic_arbiter #(.N(N), .SETTLE(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_mode(req0_mode), .req0_angle(req0_angle),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_mode(req1_mode), .req1_angle(req1_angle),
        .req1_x(req1_x), .req1_y(req1_y),
        .cu_trig_rot(cu_trig_rot), .cu_angle(cu_angle),
        .cu_xi(cu_xi), .cu_yi(cu_yi),
        .cu_sin(cu_sin), .cu_cos(cu_cos),
        .cu_xr(cu_xr), .cu_yr(cu_yr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_a(rsp_a), .rsp_b(rsp_b),
        .busy(busy)
    );

    // CORDIC stub: exact results for the directed angles, distinct
    // filler values otherwise so a wrong mux choice is visible.
    always_comb begin
        cu_sin = 32'h11111111;
        cu_cos = 32'h22222222;
        cu_xr  = 32'h33333333;
        cu_yr  = 32'h44444444;
        if (cu_angle == PI3) begin
            cu_sin = SIN60;
            cu_cos = HALF;
        end
        if (cu_angle == PI6 && cu_xi == ONE && cu_yi == '0) begin
            cu_xr = SIN60;
            cu_yr = HALF;
        end
        if (cu_angle == PIA) begin
            cu_sin = 32'h00000000;
            cu_cos = 32'hF0000000;
        end
        if (cu_angle == 32'hFFFFFFFF) begin
            cu_sin = 32'hFFFFFFFF;
            cu_cos = ONE;
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_rsp(input string tag);
        int cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 64'(rsp_valid), 64'd1);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [N-1:0] held_a;
    logic         seen;

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 0; req0_mode = 0;
        req0_angle = '0; req0_x = '0; req0_y = '0;
        req1_valid = 0; req1_mode = 0;
        req1_angle = '0; req1_x = '0; req1_y = '0;

        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        #1;
        check("rdy_in_rst", 64'(req0_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rvalid", 64'(rsp_valid), 64'd0);
        check("rst_rid", 64'(rsp_id), 64'd0);
        check("rst_rsp_a", 64'(rsp_a), 64'd0);
        check("rst_rsp_b", 64'(rsp_b), 64'd0);
        check("rst_cu_ang", 64'(cu_angle), 64'd0);
        check("rst_cu_mode", 64'(cu_trig_rot), 64'd0);
        rst = 1'b0;
        req0_valid = 1'b0;

        // Trig on req0, exact SETTLE latency, inputs changed in flight.
        @(negedge clk);
        req0_valid = 1'b1; req0_mode = 1'b1;
        req0_angle = PI3; req0_x = 32'h12345678;
        #1;
        check("t1_rdy0", 64'(req0_ready), 64'd1);
        @(negedge clk);
        req0_valid = 1'b0; req0_mode = 1'b0; req0_angle = '0;
        #1;
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_cu_ang", 64'(cu_angle), 64'(PI3));
        check("t1_cu_mode", 64'(cu_trig_rot), 64'd1);
        repeat (3) @(negedge clk);
        check("t1_early", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check("t1_valid", 64'(rsp_valid), 64'd1);
        check("t1_id", 64'(rsp_id), 64'd0);
        check("t1_sin", 64'(rsp_a), 64'(SIN60));
        check("t1_cos", 64'(rsp_b), 64'(HALF));
        release_rsp();
        check("t1_clr", 64'(rsp_valid), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);

        // Rotate on req1.
        req1_valid = 1'b1; req1_mode = 1'b0;
        req1_angle = PI6; req1_x = ONE; req1_y = '0;
        #1;
        check("t2_rdy1", 64'(req1_ready), 64'd1);
        check("t2_rdy0", 64'(req0_ready), 64'd0);
        @(negedge clk);
        req1_valid = 1'b0; req1_x = 32'h0;
        wait_rsp("t2_timeout");
        check("t2_id", 64'(rsp_id), 64'd1);
        check("t2_xr", 64'(rsp_a), 64'(SIN60));
        check("t2_yr", 64'(rsp_b), 64'(HALF));
        release_rsp();

        // Round robin from reset with both requesters always valid.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_mode = 1'b1; req0_angle = PI3;
        req1_valid = 1'b1; req1_mode = 1'b0;
        req1_angle = PI6; req1_x = ONE; req1_y = '0;
        #1;
        check("t3_tie_rdy0", 64'(req0_ready), 64'd1);
        check("t3_tie_rdy1", 64'(req1_ready), 64'd0);
        @(negedge clk);
        check("t3_busy_rdy", 64'({req1_ready, req0_ready}), 64'd0);
        wait_rsp("t3a_timeout");
        check("t3a_id", 64'(rsp_id), 64'd0);
        rsp_ready = 1'b1;
        #1;
        check("t3_hs_rdy", 64'({req1_ready, req0_ready}), 64'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("t3_next_rdy", 64'({req1_ready, req0_ready}), 64'd2);
        @(negedge clk);
        wait_rsp("t3b_timeout");
        check("t3b_id", 64'(rsp_id), 64'd1);
        check("t3b_xr", 64'(rsp_a), 64'(SIN60));

        // Hold response for 5 cycles with requesters still valid.
        held_a = rsp_a;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_v", 64'(rsp_valid), 64'd1);
            check("t4_hold_a", 64'(rsp_a), 64'(held_a));
            check("t4_hold_rdy", 64'({req1_ready, req0_ready}), 64'd0);
        end
        release_rsp();
        #1;
        check("t4_rr_rdy", 64'({req1_ready, req0_ready}), 64'd1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp("t3c_timeout");
        check("t3c_id", 64'(rsp_id), 64'd0);
        check("t3c_sin", 64'(rsp_a), 64'(SIN60));
        release_rsp();

        // Reset while waiting on the CORDIC unit.
        req0_valid = 1'b1; req0_mode = 1'b1; req0_angle = PI3;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rvalid", 64'(rsp_valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_cu_ang", 64'(cu_angle), 64'd0);
        check("t5_cu_mode", 64'(cu_trig_rot), 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        check("t5_stale", 64'(seen), 64'd0);

        // Angle just below pi: folded or passed through.
        req0_valid = 1'b1; req0_mode = 1'b1; req0_angle = PIA;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
`ifdef CORDIC_ARB_QUADRANT_EN
        check("t6_cu_ang", 64'(cu_angle), 64'h0FFFFFFFF);
`else
        check("t6_cu_ang", 64'(cu_angle), 64'(PIA));
`endif
        wait_rsp("t6_timeout");
`ifdef CORDIC_ARB_QUADRANT_EN
        check("t6_sin", 64'(rsp_a), 64'h00000001);
`else
        check("t6_sin", 64'(rsp_a), 64'h00000000);
`endif
        check("t6_cos", 64'(rsp_b), 64'hF0000000);
        release_rsp();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
